// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine with HI/LO result
// registers. One bit is processed per cycle: shift-add for multiply,
// restoring division for divide. Signed operations run on magnitudes and
// fix up the signs when the result is committed.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT              state;
    stateT              nextState;

    // Latched operation context
    logic [1:0]         opReg;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic               signA;
    logic               signB;
    logic [CW-1:0]      count;
    logic               dbzFlag;

    // Shared 2*WIDTH working register: {upper, lower} for multiply,
    // {remainder, dividend/quotient} for divide
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;

    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;

    logic               loadOp;
    logic               finishOp;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;

    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic               divFits;
    logic [WIDTH-1:0]   divRem;

    logic               isSigned;
    logic               divisorZero;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [WIDTH-1:0]   resultHi;
    logic [WIDTH-1:0]   resultLo;

    // Operand magnitudes: signed ops take the absolute value, unsigned pass through
    always_comb begin
        absA = operand_a;
        absB = operand_b;
        if (!op[0]) begin
            if (operand_a[WIDTH-1]) begin
                absA = -operand_a;
            end
            if (operand_b[WIDTH-1]) begin
                absB = -operand_b;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic plus the load/commit strobes that go with each transition
    always_comb begin
        nextState = state;
        loadOp    = 1'b0;
        finishOp  = 1'b0;
        if (flush) begin
            nextState = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        nextState = RUN;
                        loadOp    = 1'b1;
                    end
                end
                RUN: begin
                    if (count == '0) begin
                        nextState = DONE;
                        finishOp  = 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        nextState = RUN;
                        loadOp    = 1'b1;
                    end else begin
                        nextState = IDLE;
                    end
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magA} : '0);
        divShift = acc[2*WIDTH-1:WIDTH-1];
        divFits  = divShift >= {1'b0, magB};
        divRem   = divShift[WIDTH-1:0] - magB;
        if (!opReg[1]) begin
            accNext = {mulSum, acc[WIDTH-1:1]};
        end else if (divFits) begin
            accNext = {divRem, acc[WIDTH-2:0], 1'b1};
        end else begin
            accNext = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    // Final sign correction applied to the last iteration's value
    always_comb begin
        isSigned    = ~opReg[0];
        divisorZero = opReg[1] && (magB == '0);
        product     = accNext;
        quotient    = accNext[WIDTH-1:0];
        remainder   = accNext[2*WIDTH-1:WIDTH];
        if (isSigned && (signA ^ signB)) begin
            product  = -accNext;
            quotient = -accNext[WIDTH-1:0];
        end
        if (isSigned && signA) begin
            remainder = -accNext[2*WIDTH-1:WIDTH];
        end
        if (opReg[1]) begin
            resultHi = remainder;
            resultLo = quotient;
        end else begin
            resultHi = product[2*WIDTH-1:WIDTH];
            resultLo = product[WIDTH-1:0];
        end
    end

    // Operation context and iteration register
    always_ff @(posedge clk) begin
        if (!reset) begin
            opReg   <= '0;
            magA    <= '0;
            magB    <= '0;
            signA   <= 1'b0;
            signB   <= 1'b0;
            count   <= '0;
            acc     <= '0;
            dbzFlag <= 1'b0;
        end else if (loadOp) begin
            opReg   <= op;
            magA    <= absA;
            magB    <= absB;
            signA   <= operand_a[WIDTH-1];
            signB   <= operand_b[WIDTH-1];
            count   <= CW'(WIDTH - 1);
            acc     <= op[1] ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
            dbzFlag <= 1'b0;
        end else if (state == RUN && !flush) begin
            acc   <= accNext;
            count <= count - 1'b1;
            if (finishOp) begin
                dbzFlag <= divisorZero;
            end
        end
    end

    // HI/LO: commit on RUN->DONE, MTHI/MTLO outside of RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            hiReg <= '0;
            loReg <= '0;
        end else begin
            if (finishOp && !divisorZero) begin
                hiReg <= resultHi;
                loReg <= resultLo;
            end
            if (state != RUN) begin
                if (hi_we) begin
                    hiReg <= write_data;
                end
                if (lo_we) begin
                    loReg <= write_data;
                end
            end
        end
    end

    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign div_by_zero = (state == DONE) && dbzFlag;
    assign hi          = hiReg;
    assign lo          = loReg;

endmodule
